// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tap_pkg
// Description : Shared TAP definitions: 16-state controller encoding,
//               instruction opcodes, defaults and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tap_pkg;

    localparam int          IR_W_DEFAULT   = 3;
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

    // 1149.1 controller states, explicit 4-bit encoding
    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PA_DR  = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PA_IR  = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_e;

    // Instruction opcodes (3-bit reference values, resized to IR_W at use)
    localparam logic [2:0] OP_EXTEST  = 3'b000;
    localparam logic [2:0] OP_SAMPLE  = 3'b001;
    localparam logic [2:0] OP_IDCODE  = 3'b010;
    localparam logic [2:0] OP_RUNBIST = 3'b011;
    localparam logic [2:0] OP_BYPASS  = 3'b111;

    // Which data register sits between tdi and tdo
    typedef enum logic [1:0] {
        DR_BOUNDARY = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_BYPASS   = 2'd2
    } dr_sel_e;

    // True in the two states where tdo is driven
    function automatic logic is_shift_state(input tap_state_e s);
        return (s == SH_IR) || (s == SH_DR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tap_ctrl_if
// Description : Pad-side serial pins plus boundary-chain / BILBO control
//               bundle of the TAP controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tap_ctrl_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;
    logic bsr_so;
    logic bsr_si;
    logic bsr_capture;
    logic bsr_shift;
    logic bsr_en;
    logic bsr_update;
    logic bsr_sel;
    logic bist_b1;
    logic bist_b2;

    // Controller side
    modport master (
        input  tms, tdi, bsr_so,
        output tdo, tdo_en, bsr_si, bsr_capture, bsr_shift, bsr_en,
               bsr_update, bsr_sel, bist_b1, bist_b2
    );

    // Pads / boundary chain side
    modport slave (
        output tms, tdi, bsr_so,
        input  tdo, tdo_en, bsr_si, bsr_capture, bsr_shift, bsr_en,
               bsr_update, bsr_sel, bist_b1, bist_b2
    );
endinterface
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tap_fsm
// Description : 16-state TAP controller; state register and tms-driven
//               next-state logic. Exposes current and next state.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_fsm
    import tap_pkg::*;
(
    input  wire        clock,
    input  wire        rst_l,
    input  wire        tms,
    output tap_state_e state,
    output tap_state_e state_next
);

    tap_state_e state_q;
    tap_state_e state_d;

    // Next-state decode: 1149.1 transition graph driven by tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // State register; reset parks the controller in TLR from any state
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule
`default_nettype wire

// File: rtl/tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tap_ctrl
// Description : IEEE 1149.1 TAP controller: instruction register, IDCODE
//               and bypass data registers, tdo mux, boundary-chain strobes
//               and BILBO mode lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int          IR_W   = IR_W_DEFAULT,
    parameter logic [31:0] IDCODE = IDCODE_DEFAULT
) (
    input  wire               clock,
    input  wire               rst_l,
    tap_ctrl_if.master        bus
);

    localparam logic [IR_W-1:0] c_ir_extest  = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] c_ir_sample  = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] c_ir_idcode  = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] c_ir_runbist = IR_W'(OP_RUNBIST);
    localparam logic [IR_W-1:0] c_ir_bypass  = IR_W'(OP_BYPASS);
    // Capture pattern: LSBs 01 as 1149.1 requires
    localparam logic [IR_W-1:0] c_ir_capture = IR_W'(1);

    tap_state_e w_state;
    tap_state_e w_state_next;

    logic [IR_W-1:0] ir_q,     ir_d;
    logic [IR_W-1:0] ir_sr_q,  ir_sr_d;
    logic [31:0]     id_sr_q,  id_sr_d;
    logic            bypass_q, bypass_d;
    logic            tlr_prev_q, tlr_prev_d;

    dr_sel_e w_dr_sel;
    logic    w_tdo;
    logic    w_bsr_capture;
    logic    w_bsr_shift;
    logic    w_bsr_en;
    logic    w_bsr_update;
    logic    w_tlr_entry;

    tap_fsm u_fsm (
        .clock      (clock),
        .rst_l      (rst_l),
        .tms        (bus.tms),
        .state      (w_state),
        .state_next (w_state_next)
    );

    // Data-register select from the active instruction; unknown codes bypass
    always_comb begin
        w_dr_sel = DR_BYPASS;
        case (ir_q)
            c_ir_extest, c_ir_sample: w_dr_sel = DR_BOUNDARY;
            c_ir_idcode:              w_dr_sel = DR_IDCODE;
            c_ir_runbist, c_ir_bypass: w_dr_sel = DR_BYPASS;
            default:                  w_dr_sel = DR_BYPASS;
        endcase
    end

    // Register next values: active IR loads on the edge into TLR/UPD_IR so the
    // new instruction is already in force during that state
    always_comb begin
        ir_d       = ir_q;
        ir_sr_d    = ir_sr_q;
        id_sr_d    = id_sr_q;
        bypass_d   = bypass_q;
        tlr_prev_d = (w_state == TLR);

        if (w_state_next == TLR) begin
            ir_d = c_ir_idcode;
        end else if (w_state_next == UPD_IR) begin
            ir_d = ir_sr_q;
        end

        case (w_state)
            CAP_IR: ir_sr_d = c_ir_capture;
            SH_IR:  ir_sr_d = {bus.tdi, ir_sr_q[IR_W-1:1]};
            CAP_DR: begin
                if (w_dr_sel == DR_IDCODE) id_sr_d  = IDCODE;
                if (w_dr_sel == DR_BYPASS) bypass_d = 1'b0;
            end
            SH_DR: begin
                if (w_dr_sel == DR_IDCODE) id_sr_d  = {bus.tdi, id_sr_q[31:1]};
                if (w_dr_sel == DR_BYPASS) bypass_d = bus.tdi;
            end
            default: ;
        endcase
    end

    // Register bank with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            ir_q       <= c_ir_idcode;
            ir_sr_q    <= c_ir_capture;
            id_sr_q    <= '0;
            bypass_q   <= 1'b0;
            tlr_prev_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_sr_q    <= ir_sr_d;
            id_sr_q    <= id_sr_d;
            bypass_q   <= bypass_d;
            tlr_prev_q <= tlr_prev_d;
        end
    end

    // tdo mux and Moore boundary strobes decoded from state + active IR
    always_comb begin
        w_tdo         = 1'b0;
        w_bsr_capture = 1'b0;
        w_bsr_shift   = 1'b0;
        w_bsr_en      = 1'b0;
        w_bsr_update  = 1'b0;

        case (w_state)
            SH_IR: w_tdo = ir_sr_q[0];
            SH_DR: begin
                case (w_dr_sel)
                    DR_BOUNDARY: w_tdo = bus.bsr_so;
                    DR_IDCODE:   w_tdo = id_sr_q[0];
                    default:     w_tdo = bypass_q;
                endcase
            end
            default: ;
        endcase

        if (w_dr_sel == DR_BOUNDARY) begin
            w_bsr_capture = (w_state == CAP_DR) || (w_state == SH_DR);
            w_bsr_shift   = (w_state == SH_DR);
            w_bsr_en      = (w_state == CAP_DR) || (w_state == SH_DR);
            w_bsr_update  = (w_state == UPD_DR);
        end
    end

    // First cycle after entering TLR (or after reset) drops both BILBO lines
    assign w_tlr_entry = (w_state == TLR) && !tlr_prev_q;

    assign bus.tdo         = w_tdo;
    assign bus.tdo_en      = is_shift_state(w_state);
    assign bus.bsr_si      = bus.tdi;
    assign bus.bsr_capture = w_bsr_capture;
    assign bus.bsr_shift   = w_bsr_shift;
    assign bus.bsr_en      = w_bsr_en;
    assign bus.bsr_update  = w_bsr_update;
    assign bus.bsr_sel     = (ir_q == c_ir_extest);
    assign bus.bist_b1     = !w_tlr_entry;
    assign bus.bist_b2     = (ir_q == c_ir_runbist) && (w_state == RTI);

endmodule
`default_nettype wire

// File: tb/tb_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_ctrl
// Description : Self-checking bench for tap_ctrl: vector tables and scripted
//               TAP sequences with a queue-based output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_ctrl;
    import tap_pkg::*;

    localparam logic [31:0] C_IDCODE = 32'h1000_0001;
    localparam logic [8:0]  C_ALL    = 9'h1FF;
    localparam logic [8:0]  C_NONE   = 9'h000;

    // Output vector order: {tdo, tdo_en, cap, shift, en, upd, sel, b1, b2}
    typedef struct {
        string      name;
        logic [8:0] exp;
        logic [8:0] mask;
    } sb_t;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       so;
        logic [8:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic rst_l;
    int   n_cmp  = 0;
    int   n_fail = 0;
    sb_t  sb_q[$];
    sb_t  chk_item;
    logic [8:0] chk_act;
    vec_t bsr_tab[8];
    vec_t byp_tab[9];

    tap_ctrl_if bus ();

    tap_ctrl #(.IR_W(3), .IDCODE(C_IDCODE)) dut (
        .clock (clock),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer: compare outputs at the falling edge
    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            chk_item = sb_q.pop_front();
            chk_act  = {bus.tdo, bus.tdo_en, bus.bsr_capture, bus.bsr_shift, bus.bsr_en,
                        bus.bsr_update, bus.bsr_sel, bus.bist_b1, bus.bist_b2};
            n_cmp++;
            if ((chk_act & chk_item.mask) !== (chk_item.exp & chk_item.mask)) begin
                n_fail++;
                $display("FAIL %s: outputs %b, expected %b (mask %b)",
                         chk_item.name, chk_act, chk_item.exp, chk_item.mask);
            end
        end
    end

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One TCK: drive inputs, queue expected outputs, return just after negedge
    task automatic tick(input logic t_tms, input logic t_tdi, input logic t_so,
                        input string nm, input logic [8:0] e, input logic [8:0] m);
        bus.tms    = t_tms;
        bus.tdi    = t_tdi;
        bus.bsr_so = t_so;
        if (m != C_NONE) sb_q.push_back('{nm, e, m});
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    // From RTI: shift op into IR, checking the 001 capture, then update
    task automatic load_ir(input logic [2:0] op, input logic old_sel);
        logic [8:0] b_old;
        logic [8:0] b_new;
        b_old = 9'h002 | (old_sel ? 9'h004 : 9'h000);
        b_new = 9'h002 | ((op == 3'b000) ? 9'h004 : 9'h000);
        tick(1'b1, 1'b0,  1'b0, "ld_sel_dr",  b_old,          C_ALL);
        tick(1'b1, 1'b0,  1'b0, "ld_sel_ir",  b_old,          C_ALL);
        tick(1'b0, 1'b0,  1'b0, "ld_cap_ir",  b_old,          C_ALL);
        tick(1'b0, 1'b0,  1'b0, "ld_capbit0", b_old | 9'h180, C_ALL);
        tick(1'b0, op[0], 1'b0, "ld_capbit1", b_old | 9'h080, C_ALL);
        tick(1'b0, op[1], 1'b0, "ld_capbit2", b_old | 9'h080, C_ALL);
        tick(1'b1, op[2], 1'b0, "ld_ex1_ir",  b_old,          C_ALL);
        tick(1'b1, 1'b0,  1'b0, "ld_upd_ir",  b_new,          C_ALL);
        check_val("ir_loaded", 32'(dut.ir_q), 32'(op));
        tick(1'b0, 1'b0,  1'b0, "ld_rti",
             b_new | ((op == 3'b011) ? 9'h001 : 9'h000), C_ALL);
    endtask

    task automatic run_bsr_tab(input logic sel);
        for (int i = 0; i < 8; i++) begin
            tick(bsr_tab[i].tms, bsr_tab[i].tdi, bsr_tab[i].so,
                 $sformatf("bsr_tab[%0d] sel=%0b", i, sel),
                 bsr_tab[i].exp | (sel ? 9'h004 : 9'h000), C_ALL);
        end
    endtask

    task automatic run_byp_tab(input string tag);
        for (int i = 0; i < 9; i++) begin
            tick(byp_tab[i].tms, byp_tab[i].tdi, byp_tab[i].so,
                 $sformatf("%s[%0d]", tag, i), byp_tab[i].exp, C_ALL);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Boundary table (bsr_sel bit added at run time)
        bsr_tab[0] = '{1'b1, 1'b0, 1'b0, 9'h002};  // SEL_DR
        bsr_tab[1] = '{1'b0, 1'b0, 1'b0, 9'h052};  // CAP_DR: capture, en
        bsr_tab[2] = '{1'b0, 1'b0, 1'b1, 9'h1F2};  // SH_DR, tdo = bsr_so = 1
        bsr_tab[3] = '{1'b0, 1'b1, 1'b0, 9'h0F2};  // SH_DR, tdo = bsr_so = 0
        bsr_tab[4] = '{1'b0, 1'b0, 1'b1, 9'h1F2};  // SH_DR
        bsr_tab[5] = '{1'b1, 1'b0, 1'b0, 9'h002};  // EX1_DR
        bsr_tab[6] = '{1'b1, 1'b0, 1'b0, 9'h00A};  // UPD_DR: update
        bsr_tab[7] = '{1'b0, 1'b0, 1'b0, 9'h002};  // RTI: update gone
        // Bypass table; bsr_so held high so a boundary-selected tdo shows up
        byp_tab[0] = '{1'b1, 1'b0, 1'b1, 9'h002};  // SEL_DR
        byp_tab[1] = '{1'b0, 1'b0, 1'b1, 9'h002};  // CAP_DR, no strobes
        byp_tab[2] = '{1'b0, 1'b0, 1'b1, 9'h082};  // SH_DR, captured 0
        byp_tab[3] = '{1'b0, 1'b1, 1'b1, 9'h182};  // tdi 1 -> tdo 1
        byp_tab[4] = '{1'b0, 1'b0, 1'b1, 9'h082};  // tdi 0 -> tdo 0
        byp_tab[5] = '{1'b0, 1'b1, 1'b1, 9'h182};  // tdi 1 -> tdo 1
        byp_tab[6] = '{1'b1, 1'b1, 1'b1, 9'h002};  // EX1_DR
        byp_tab[7] = '{1'b1, 1'b0, 1'b1, 9'h002};  // UPD_DR, no update strobe
        byp_tab[8] = '{1'b0, 1'b0, 1'b1, 9'h002};  // RTI

        bus.tms = 1'b1; bus.tdi = 1'b0; bus.bsr_so = 1'b0;

        // Reset, then read IDCODE LSB-first
        rst_l = 1'b0;
        tick(1'b1, 1'b0, 1'b0, "reset_outputs", 9'h000, C_ALL);
        check_val("reset_ir", 32'(dut.ir_q), 32'h2);
        check_val("reset_state", 32'(dut.w_state), 32'(TLR));
        rst_l = 1'b1;
        tick(1'b0, 1'b0, 1'b0, "rti", 9'h002, C_ALL);
        tick(1'b1, 1'b0, 1'b0, "sel_dr", 9'h002, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "cap_dr_id", 9'h002, C_ALL);
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0, 1'b0, $sformatf("idcode_bit%0d", i),
                 {C_IDCODE[i], 8'h82}, C_ALL);
        end
        tick(1'b1, 1'b0, 1'b0, "id_ex1", 9'h002, C_ALL);
        tick(1'b1, 1'b0, 1'b0, "id_upd", 9'h002, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "id_rti", 9'h002, C_ALL);

        // Reset in the middle of an IDCODE shift
        tick(1'b1, 1'b0, 1'b0, "mid_sel_dr", 9'h002, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "mid_cap_dr", 9'h002, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "mid_bit0", {C_IDCODE[0], 8'h82}, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "mid_bit1", {C_IDCODE[1], 8'h82}, C_ALL);
        rst_l = 1'b0;
        tick(1'b0, 1'b0, 1'b0, "mid_reset_outputs", 9'h000, C_ALL);
        rst_l = 1'b1;
        check_val("mid_reset_state", 32'(dut.w_state), 32'(TLR));
        check_val("mid_reset_ir", 32'(dut.ir_q), 32'h2);
        tick(1'b1, 1'b0, 1'b0, "tlr_second_cycle", 9'h002, C_ALL);
        tick(1'b0, 1'b0, 1'b0, "back_to_rti", 9'h002, C_ALL);

        // Five tms=1 from PA_IR with EXTEST waiting in the IR shift register
        tick(1'b1, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b1, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b0, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b0, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b0, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b0, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b1, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b0, 1'b0, 1'b0, "pa_ir", 9'h002, C_ALL);
        check_val("pa_ir_state", 32'(dut.w_state), 32'(PA_IR));
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, "", 9'h000, C_NONE);
        tick(1'b1, 1'b0, 1'b0, "five_ones_tlr", 9'h000, C_ALL);
        check_val("five_ones_state", 32'(dut.w_state), 32'(TLR));
        check_val("five_ones_ir", 32'(dut.ir_q), 32'h2);
        tick(1'b0, 1'b0, 1'b0, "rti_after_tlr", 9'h002, C_ALL);

        // EXTEST, then SAMPLE: boundary strobes
        load_ir(3'b000, 1'b0);
        run_bsr_tab(1'b1);
        load_ir(3'b001, 1'b1);
        run_bsr_tab(1'b0);

        // BYPASS and an undefined opcode: one-cycle delay, no strobes
        load_ir(3'b111, 1'b0);
        run_byp_tab("bypass111");
        load_ir(3'b101, 1'b0);
        run_byp_tab("bypass101");

        // RUNBIST: BILBO lines across RTI and TLR entry
        load_ir(3'b011, 1'b0);
        tick(1'b0, 1'b0, 1'b0, "rb_rti_hold", 9'h003, C_ALL);
        tick(1'b1, 1'b0, 1'b0, "rb_sel_dr", 9'h002, C_ALL);
        tick(1'b1, 1'b0, 1'b0, "rb_sel_ir", 9'h002, C_ALL);
        tick(1'b1, 1'b0, 1'b0, "rb_tlr_entry", 9'h000, C_ALL);
        check_val("rb_tlr_ir", 32'(dut.ir_q), 32'h2);
        tick(1'b1, 1'b0, 1'b0, "rb_tlr_hold", 9'h002, C_ALL);

        // bsr_si follows tdi
        bus.tdi = 1'b1; #1;
        check_val("bsr_si_hi", 32'(bus.bsr_si), 32'd1);
        bus.tdi = 1'b0; #1;
        check_val("bsr_si_lo", 32'(bus.bsr_si), 32'd0);

        @(negedge clock); #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
